alu_iter_muldiv: RTL and testbench



---
 rtl/alu_iter_muldiv.sv | 162 ++++++++++++++++
 tb/tb_alu_iter_muldiv.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative shift-add multiply / restoring divide, one result bit per clock.
// Signed operation is compiled in with `define ALU_MULDIV_SIGNED_EN; otherwise all ops are unsigned.
module alu_iter_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_ovf,
  output logic             flag_dbz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   sgn_in;
  logic                   op_div_q, sgn_q, neg_lo_q, neg_hi_q, min_ovf_q;
  logic [CNT_W-1:0]       cnt;
  logic [2*WIDTH-1:0]     acc, acc_step, prod;
  logic [WIDTH-1:0]       opb, addend, mag_a, mag_b, fin_lo, fin_hi;
  logic [WIDTH:0]         mul_sum, div_shift, div_diff;
  logic                   div_ge, last_iter, div_by_zero, min_neg1, fin_ovf;

  function automatic logic [WIDTH-1:0] mag_w(input logic signed [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH-1:0] neg_x;
    neg_x = -x;
    return (sgn && x[WIDTH-1]) ? neg_x : x;
  endfunction

  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

`ifdef ALU_MULDIV_SIGNED_EN
  assign sgn_in = is_signed;
`else
  logic unused_is_signed;
  assign sgn_in           = 1'b0;
  assign unused_is_signed = is_signed;
`endif

  assign mag_a       = mag_w(in_a, sgn_in);
  assign mag_b       = mag_w(in_b, sgn_in);
  assign div_by_zero = op_div && (in_b == '0);
  assign min_neg1    = sgn_in && op_div && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);
  assign last_iter   = (cnt == CNT_W'(1));

  // One iteration: MUL keeps {hi, multiplier} in acc, DIV keeps {remainder, dividend}.
  always_comb begin
    addend    = acc[0] ? opb : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = (div_shift >= {1'b0, opb});
    if (op_div_q)
      acc_step = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                        : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign fixup and flags, applied on the last BUSY edge.
  always_comb begin
    prod = fix_2w(acc_step, neg_lo_q);
    if (op_div_q) begin
      fin_lo  = fix_w(acc_step[WIDTH-1:0], neg_lo_q);
      fin_hi  = fix_w(acc_step[2*WIDTH-1:WIDTH], neg_hi_q);
      fin_ovf = min_ovf_q;
    end else begin
      fin_lo  = prod[WIDTH-1:0];
      fin_hi  = prod[2*WIDTH-1:WIDTH];
      fin_ovf = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                      : (prod[2*WIDTH-1:WIDTH] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = div_by_zero ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_div_q  <= 1'b0;
      sgn_q     <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      min_ovf_q <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      flag_zero <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_dbz  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_div_q  <= op_div;
          sgn_q     <= sgn_in;
          neg_lo_q  <= sgn_in && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          neg_hi_q  <= sgn_in && in_a[WIDTH-1];
          min_ovf_q <= min_neg1;
          cnt       <= CNT_W'(WIDTH);
          acc       <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
          opb       <= op_div ? mag_b : mag_a;
          if (div_by_zero) begin
            result_lo <= '1;
            result_hi <= in_a;
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_dbz  <= 1'b1;
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
          if (last_iter) begin
            result_lo <= fin_lo;
            result_hi <= fin_hi;
            flag_zero <= (fin_lo == '0);
            flag_ovf  <= fin_ovf;
            flag_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_muldiv.sv
// Directed self-checking bench for alu_iter_muldiv (WIDTH=16); signed vectors apply when
// ALU_MULDIV_SIGNED_EN is defined, otherwise is_signed must be ignored.
module tb_alu_iter_muldiv;
  localparam int W = 16;

  logic         clk, rst_n, in_valid, in_ready, op_div, is_signed;
  logic [W-1:0] in_a, in_b, result_lo, result_hi;
  logic         out_valid, out_ready, flag_zero, flag_ovf, flag_dbz;
  int           total, bad;

  alu_iter_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_div(op_div), .is_signed(is_signed), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .result_lo(result_lo),
    .result_hi(result_hi), .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_dbz(flag_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // edges counts clock edges after the accept edge until out_valid is seen
  task automatic run_op(input logic div, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int edges);
    op_div = div; is_signed = sgn; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if ({result_hi, result_lo} !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 00000000", {result_hi, result_lo}); end
    total++; if ({flag_zero, flag_ovf, flag_dbz} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {flag_zero, flag_ovf, flag_dbz}); end
  endtask

  task automatic test_mul();
    int e;
    run_op(1'b0, 1'b0, 16'd300, 16'd400, e);
    total++; if (e !== 16) begin bad++; $display("FAIL mul_latency got %0d want 16", e); end
    total++; if ({result_hi, result_lo} !== 32'h0001_D4C0) begin bad++; $display("FAIL mul_300x400 got %h want 0001d4c0", {result_hi, result_lo}); end
    total++; if ({flag_zero, flag_ovf, flag_dbz} !== 3'b010) begin bad++; $display("FAIL mul_300x400_flags got %b want 010", {flag_zero, flag_ovf, flag_dbz}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_done_in_ready got %b want 0", in_ready); end
    release_out();
    run_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, e);
    total++; if ({result_hi, result_lo} !== 32'hFFFE_0001) begin bad++; $display("FAIL mul_max got %h want fffe0001", {result_hi, result_lo}); end
    total++; if ({flag_zero, flag_ovf, flag_dbz} !== 3'b010) begin bad++; $display("FAIL mul_max_flags got %b want 010", {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
    run_op(1'b0, 1'b0, 16'h1234, 16'h0000, e);
    total++; if ({result_hi, result_lo} !== 32'h0) begin bad++; $display("FAIL mul_zero got %h want 00000000", {result_hi, result_lo}); end
    total++; if ({flag_zero, flag_ovf, flag_dbz} !== 3'b100) begin bad++; $display("FAIL mul_zero_flags got %b want 100", {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int e;
    run_op(1'b1, 1'b0, 16'd100, 16'd7, e);
    total++; if (e !== 16) begin bad++; $display("FAIL b2b_first_latency got %0d want 16", e); end
    total++; if ({result_hi, result_lo} !== {16'd2, 16'd14}) begin bad++; $display("FAIL b2b_100div7 got %h want 0002000e", {result_hi, result_lo}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_done_in_ready got %b want 0", in_ready); end
    // second op is presented while the first result is being released
    op_div = 1'b1; in_a = 16'd10; in_b = 16'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL b2b_after_handshake got %b want 01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_in_ready got %b want 0", in_ready); end
    e = 0;
    while (!out_valid && e < 60) begin
      @(posedge clk); #1;
      e++;
    end
    total++; if (e !== 16) begin bad++; $display("FAIL b2b_second_latency got %0d want 16", e); end
    total++; if ({result_hi, result_lo} !== {16'd0, 16'd5}) begin bad++; $display("FAIL b2b_10div2 got %h want 00000005", {result_hi, result_lo}); end
    release_out();
  endtask

  task automatic test_dbz();
    int e;
    run_op(1'b1, 1'b0, 16'd1234, 16'd0, e);
    total++; if (e !== 0) begin bad++; $display("FAIL dbz_latency got %0d want 0 edges after accept", e); end
    total++; if ({result_hi, result_lo} !== 32'h04D2_FFFF) begin bad++; $display("FAIL dbz_result got %h want 04d2ffff", {result_hi, result_lo}); end
    total++; if ({flag_zero, flag_ovf, flag_dbz} !== 3'b001) begin bad++; $display("FAIL dbz_flags got %b want 001", {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL dbz_release got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_backpressure();
    int e;
    run_op(1'b1, 1'b0, 16'd1000, 16'd10, e);
    for (int i = 0; i < 5; i++) begin
      in_a = 16'(i * 37 + 5); in_b = 16'(i + 1); op_div = i[0];
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, flag_zero, flag_ovf, flag_dbz, result_hi, result_lo} !==
          {1'b1, 1'b0, 3'b000, 16'd0, 16'd100}) begin
        bad++;
        $display("FAIL backpressure_hold cycle %0d got %b_%b_%b_%h_%h want 1_0_000_0000_0064",
                 i, out_valid, in_ready, {flag_zero, flag_ovf, flag_dbz}, result_hi, result_lo);
      end
    end
    release_out();
    total++; if ({out_valid, in_ready, result_lo} !== {1'b0, 1'b1, 16'd100}) begin bad++; $display("FAIL backpressure_release got %b_%b_%h want 0_1_0064", out_valid, in_ready, result_lo); end
  endtask

  task automatic test_reset_mid();
    int e, seen;
    op_div = 1'b0; is_signed = 1'b0; in_a = 16'd300; in_b = 16'd400; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL rstmid_handshake got %b want 10", {in_ready, out_valid}); end
    total++; if ({result_hi, result_lo, flag_zero, flag_ovf, flag_dbz} !== 35'h0) begin bad++; $display("FAIL rstmid_outputs got %h_%b want 00000000_000", {result_hi, result_lo}, {flag_zero, flag_ovf, flag_dbz}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_result got %0d valid cycles want 0", seen); end
    run_op(1'b0, 1'b0, 16'd3, 16'd5, e);
    total++; if (e !== 16) begin bad++; $display("FAIL rstmid_mul_latency got %0d want 16", e); end
    total++; if ({result_hi, result_lo, flag_zero, flag_ovf, flag_dbz} !== {16'd0, 16'd15, 3'b000}) begin bad++; $display("FAIL rstmid_3x5 got %h_%b want 0000000f_000", {result_hi, result_lo}, {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
  endtask

`ifdef ALU_MULDIV_SIGNED_EN
  task automatic test_signed();
    int e;
    run_op(1'b0, 1'b1, 16'hFFF9, 16'h0003, e);
    total++; if ({result_hi, result_lo, flag_zero, flag_ovf, flag_dbz} !== {32'hFFFF_FFEB, 3'b000}) begin bad++; $display("FAIL smul_m7x3 got %h_%b want ffffffeb_000", {result_hi, result_lo}, {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
    run_op(1'b1, 1'b1, 16'hFFF9, 16'h0002, e);
    total++; if ({result_hi, result_lo, flag_zero, flag_ovf, flag_dbz} !== {32'hFFFF_FFFD, 3'b000}) begin bad++; $display("FAIL sdiv_m7div2 got %h_%b want fffffffd_000", {result_hi, result_lo}, {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
    run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, e);
    total++; if (e !== 16) begin bad++; $display("FAIL sdiv_minneg1_latency got %0d want 16", e); end
    total++; if ({result_hi, result_lo, flag_zero, flag_ovf, flag_dbz} !== {32'h0000_8000, 3'b010}) begin bad++; $display("FAIL sdiv_minneg1 got %h_%b want 00008000_010", {result_hi, result_lo}, {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
  endtask
`else
  task automatic test_unsigned_only();
    int e;
    run_op(1'b1, 1'b1, 16'hFFF9, 16'h0002, e);
    total++; if ({result_hi, result_lo, flag_zero, flag_ovf, flag_dbz} !== {32'h0001_7FFC, 3'b000}) begin bad++; $display("FAIL udiv_fff9div2 got %h_%b want 00017ffc_000", {result_hi, result_lo}, {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
    run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, e);
    total++; if ({result_hi, result_lo, flag_zero, flag_ovf, flag_dbz} !== {32'h8000_0000, 3'b100}) begin bad++; $display("FAIL udiv_8000divffff got %h_%b want 80000000_100", {result_hi, result_lo}, {flag_zero, flag_ovf, flag_dbz}); end
    release_out();
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; op_div = 1'b0; is_signed = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_mul();
    test_back_to_back();
    test_dbz();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_MULDIV_SIGNED_EN
    test_signed();
`else
    test_unsigned_only();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
